// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory.
// Holds the strobes for MEM_LAT cycles, then pulses the owner's ack with registered read data.
module data_mem_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_ack,
   output logic [DW-1:0] p0_rdata,
   output logic          cpu_stall,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_ack,
   output logic [DW-1:0] p1_rdata,
   output logic          mem_w,
   output logic          mem_r,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   state_t        state, state_n;
   logic          owner;
   logic          last;
   logic [3:0]    cnt;
   logic          grant;
   logic          grant_port;
   logic          finish;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   assign cpu_stall = p0_req & ~p0_ack;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // On a tie the port that was not served last wins; last resets to 1 so port 0 wins first.
   always_comb begin
      state_n    = state;
      grant      = 1'b0;
      grant_port = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (p0_req && (!p1_req || last)) begin
               grant      = 1'b1;
               grant_port = 1'b0;
               state_n    = ACCESS;
            end else if (p1_req) begin
               grant      = 1'b1;
               grant_port = 1'b1;
               state_n    = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               finish  = 1'b1;
               state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      sel_we    = grant_port ? p1_we    : p0_we;
      sel_addr  = grant_port ? p1_addr  : p0_addr;
      sel_wdata = grant_port ? p1_wdata : p0_wdata;
   end

   // mem_w/mem_addr/mem_wdata double as the latched request fields for the whole access.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= 1'b0;
         last      <= 1'b1;
         cnt       <= '0;
         mem_w     <= 1'b0;
         mem_r     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         p0_ack    <= 1'b0;
         p1_ack    <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         if (grant) begin
            owner     <= grant_port;
            mem_w     <= sel_we;
            mem_r     <= ~sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cnt       <= CNT_INIT;
         end else if (state == ACCESS) begin
            if (finish) begin
               mem_w <= 1'b0;
               mem_r <= 1'b0;
               if (owner) begin
                  p1_ack <= 1'b1;
                  if (mem_r) p1_rdata <= mem_rdata;
               end else begin
                  p0_ack <= 1'b1;
                  if (mem_r) p0_rdata <= mem_rdata;
               end
            end else begin
               cnt <= cnt - 4'd1;
            end
         end else if (state == DONE) begin
            last <= owner;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios on MEM_LAT=1 and MEM_LAT=4 instances,
// plus randomized two-port traffic scored against an ordered reference memory.
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // instance A: MEM_LAT = 1
   logic        a_reset;
   logic        a_p0_req, a_p0_we, a_p0_ack, a_cpu_stall;
   logic [15:0] a_p0_addr, a_p0_wdata, a_p0_rdata;
   logic        a_p1_req, a_p1_we, a_p1_ack;
   logic [15:0] a_p1_addr, a_p1_wdata, a_p1_rdata;
   logic        a_mem_w, a_mem_r;
   logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [15:0] a_mem [0:65535];

   // instance B: MEM_LAT = 4
   logic        b_reset;
   logic        b_p0_req, b_p0_we, b_p0_ack, b_cpu_stall;
   logic [15:0] b_p0_addr, b_p0_wdata, b_p0_rdata;
   logic        b_p1_req, b_p1_we, b_p1_ack;
   logic [15:0] b_p1_addr, b_p1_wdata, b_p1_rdata;
   logic        b_mem_w, b_mem_r;
   logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [15:0] b_mem [0:65535];

   data_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_a (
      .clk(clk), .reset(a_reset),
      .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
      .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata), .cpu_stall(a_cpu_stall),
      .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
      .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
      .mem_w(a_mem_w), .mem_r(a_mem_r), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata)
   );

   data_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(4)) u_b (
      .clk(clk), .reset(b_reset),
      .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
      .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata), .cpu_stall(b_cpu_stall),
      .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
      .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
      .mem_w(b_mem_w), .mem_r(b_mem_r), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata)
   );

   // data_mem models: combinational read, write on the clock edge while MemW is high
   assign a_mem_rdata = a_mem[a_mem_addr];
   assign b_mem_rdata = b_mem[b_mem_addr];
   always @(posedge clk) if (a_mem_w) a_mem[a_mem_addr] <= a_mem_wdata;
   always @(posedge clk) if (b_mem_w) b_mem[b_mem_addr] <= b_mem_wdata;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic test_reset();
      a_reset = 1'b1; b_reset = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++; if ({a_mem_w, a_mem_r, a_p0_ack, a_p1_ack, a_cpu_stall} !== 5'b0)
         $display("FAIL reset_a_flags got %b exp 00000", {a_mem_w, a_mem_r, a_p0_ack, a_p1_ack, a_cpu_stall}); else pass_cnt++;
      total_cnt++; if ({a_mem_addr, a_mem_wdata} !== 32'h0)
         $display("FAIL reset_a_mem_bus got %h exp 0", {a_mem_addr, a_mem_wdata}); else pass_cnt++;
      total_cnt++; if ({a_p0_rdata, a_p1_rdata} !== 32'h0)
         $display("FAIL reset_a_rdata got %h exp 0", {a_p0_rdata, a_p1_rdata}); else pass_cnt++;
      total_cnt++; if ({b_mem_w, b_mem_r, b_p0_ack, b_p1_ack} !== 4'b0)
         $display("FAIL reset_b_flags got %b exp 0000", {b_mem_w, b_mem_r, b_p0_ack, b_p1_ack}); else pass_cnt++;
      total_cnt++; if ({b_mem_addr, b_mem_wdata, b_p0_rdata, b_p1_rdata} !== 64'h0)
         $display("FAIL reset_b_regs got %h exp 0", {b_mem_addr, b_mem_wdata, b_p0_rdata, b_p1_rdata}); else pass_cnt++;
      a_reset = 1'b0; b_reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      a_p0_req = 1'b1; a_p0_we = 1'b1; a_p0_addr = 16'h0010; a_p0_wdata = 16'hBEEF;
      #1;
      total_cnt++; if (a_cpu_stall !== 1'b1) $display("FAIL wr_stall_req got %b exp 1", a_cpu_stall); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({a_mem_w, a_mem_r} !== 2'b10) $display("FAIL wr_strobes got %b exp 10", {a_mem_w, a_mem_r}); else pass_cnt++;
      total_cnt++; if (a_mem_addr !== 16'h0010) $display("FAIL wr_addr got %h exp 0010", a_mem_addr); else pass_cnt++;
      total_cnt++; if (a_mem_wdata !== 16'hBEEF) $display("FAIL wr_wdata got %h exp beef", a_mem_wdata); else pass_cnt++;
      total_cnt++; if ({a_p0_ack, a_cpu_stall} !== 2'b01) $display("FAIL wr_stall_access got %b exp 01", {a_p0_ack, a_cpu_stall}); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({a_p0_ack, a_cpu_stall, a_mem_w} !== 3'b100) $display("FAIL wr_ack got %b exp 100", {a_p0_ack, a_cpu_stall, a_mem_w}); else pass_cnt++;
      a_p0_req = 1'b0;
      @(negedge clk);
      total_cnt++; if (a_p0_ack !== 1'b0) $display("FAIL wr_ack_pulse got %b exp 0", a_p0_ack); else pass_cnt++;
      a_p0_req = 1'b1; a_p0_we = 1'b0;
      @(negedge clk);
      total_cnt++; if ({a_mem_w, a_mem_r} !== 2'b01) $display("FAIL rd_strobes got %b exp 01", {a_mem_w, a_mem_r}); else pass_cnt++;
      total_cnt++; if (a_mem_addr !== 16'h0010) $display("FAIL rd_addr got %h exp 0010", a_mem_addr); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({a_p0_ack, a_p1_ack, a_mem_r} !== 3'b100) $display("FAIL rd_ack got %b exp 100", {a_p0_ack, a_p1_ack, a_mem_r}); else pass_cnt++;
      total_cnt++; if (a_p0_rdata !== 16'hBEEF) $display("FAIL rd_data got %h exp beef", a_p0_rdata); else pass_cnt++;
      a_p0_req = 1'b0;
      @(negedge clk);
      total_cnt++; if (a_p0_rdata !== 16'hBEEF) $display("FAIL rd_data_hold got %h exp beef", a_p0_rdata); else pass_cnt++;
   endtask

   task automatic test_tie();
      int t0 = -1;
      int t1 = -1;
      logic [15:0] rd0 = '0;
      bit both = 1'b0;
      a_p0_req = 1'b1; a_p0_we = 1'b1; a_p0_addr = 16'h0020; a_p0_wdata = 16'h5A5A;
      repeat (2) @(negedge clk);
      a_p0_req = 1'b0;
      @(negedge clk);
      a_reset = 1'b1;
      @(negedge clk);
      a_reset = 1'b0;
      a_p0_req = 1'b1; a_p0_we = 1'b0; a_p0_addr = 16'h0020;
      a_p1_req = 1'b1; a_p1_we = 1'b1; a_p1_addr = 16'h0030; a_p1_wdata = 16'h1234;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (a_p0_ack && a_p1_ack) both = 1'b1;
         if (c == 1) begin
            total_cnt++; if ({a_mem_r, a_mem_addr} !== {1'b1, 16'h0020})
               $display("FAIL tie_first_grant got %h exp 10020", {a_mem_r, a_mem_addr}); else pass_cnt++;
         end
         if (c == 4) begin
            total_cnt++; if ({a_mem_w, a_mem_addr} !== {1'b1, 16'h0030})
               $display("FAIL tie_second_grant got %h exp 10030", {a_mem_w, a_mem_addr}); else pass_cnt++;
         end
         if (a_p0_ack) begin t0 = c; rd0 = a_p0_rdata; a_p0_req = 1'b0; end
         if (a_p1_ack) begin t1 = c; a_p1_req = 1'b0; end
      end
      total_cnt++; if (t0 != 2) $display("FAIL tie_p0_ack_cycle got %0d exp 2", t0); else pass_cnt++;
      total_cnt++; if (t1 != 5) $display("FAIL tie_p1_ack_cycle got %0d exp 5", t1); else pass_cnt++;
      total_cnt++; if (rd0 !== 16'h5A5A) $display("FAIL tie_p0_rdata got %h exp 5a5a", rd0); else pass_cnt++;
      total_cnt++; if (a_mem[16'h0030] !== 16'h1234) $display("FAIL tie_p1_write got %h exp 1234", a_mem[16'h0030]); else pass_cnt++;
      total_cnt++; if (both !== 1'b0) $display("FAIL tie_dual_ack got %b exp 0", both); else pass_cnt++;
   endtask

   task automatic test_contention();
      int order[$];
      int times[$];
      logic [15:0] datas[$];
      bit both = 1'b0;
      a_reset = 1'b1;
      @(negedge clk);
      a_reset = 1'b0;
      a_p0_req = 1'b1; a_p0_we = 1'b0; a_p0_addr = 16'h0020;
      a_p1_req = 1'b1; a_p1_we = 1'b0; a_p1_addr = 16'h0030;
      for (int c = 1; c <= 40 && order.size() < 6; c++) begin
         @(negedge clk);
         if (a_p0_ack && a_p1_ack) both = 1'b1;
         if (a_p0_ack) begin order.push_back(0); times.push_back(c); datas.push_back(a_p0_rdata); end
         else if (a_p1_ack) begin order.push_back(1); times.push_back(c); datas.push_back(a_p1_rdata); end
      end
      a_p0_req = 1'b0; a_p1_req = 1'b0;
      @(negedge clk);
      total_cnt++; if (order.size() != 6) $display("FAIL rr_ack_count got %0d exp 6", order.size()); else pass_cnt++;
      total_cnt++; if (both !== 1'b0) $display("FAIL rr_dual_ack got %b exp 0", both); else pass_cnt++;
      for (int i = 0; i < order.size(); i++) begin
         total_cnt++; if (order[i] != i % 2) $display("FAIL rr_order[%0d] got %0d exp %0d", i, order[i], i % 2); else pass_cnt++;
         total_cnt++; if (times[i] != 2 + 3 * i) $display("FAIL rr_time[%0d] got %0d exp %0d", i, times[i], 2 + 3 * i); else pass_cnt++;
         total_cnt++; if (datas[i] !== ((i % 2 == 0) ? 16'h5A5A : 16'h1234))
            $display("FAIL rr_rdata[%0d] got %h exp %h", i, datas[i], (i % 2 == 0) ? 16'h5A5A : 16'h1234); else pass_cnt++;
      end
   endtask

   task automatic test_latency4();
      int tw = -1;
      b_p1_req = 1'b1; b_p1_we = 1'b1; b_p1_addr = 16'h0040; b_p1_wdata = 16'h00A5;
      for (int c = 1; c <= 12 && tw < 0; c++) begin
         @(negedge clk);
         if (b_p1_ack) begin tw = c; b_p1_req = 1'b0; end
      end
      b_p1_req = 1'b0;
      @(negedge clk);
      total_cnt++; if (tw != 5) $display("FAIL lat4_write_ack got %0d exp 5", tw); else pass_cnt++;
      b_p1_req = 1'b1; b_p1_we = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         total_cnt++; if (b_mem_r !== (i <= 4)) $display("FAIL lat4_mem_r[%0d] got %b exp %b", i, b_mem_r, i <= 4); else pass_cnt++;
         total_cnt++; if (b_p1_ack !== (i == 5)) $display("FAIL lat4_ack[%0d] got %b exp %b", i, b_p1_ack, i == 5); else pass_cnt++;
         if (i <= 4) begin
            total_cnt++; if ({b_mem_w, b_mem_addr} !== {1'b0, 16'h0040})
               $display("FAIL lat4_addr[%0d] got %h exp 00040", i, {b_mem_w, b_mem_addr}); else pass_cnt++;
         end
         if (i == 5) begin
            total_cnt++; if (b_p1_rdata !== 16'h00A5) $display("FAIL lat4_rdata got %h exp 00a5", b_p1_rdata); else pass_cnt++;
            b_p1_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset_abort();
      int acks = 0;
      logic [15:0] rd1 = '0;
      b_p0_req = 1'b1; b_p0_we = 1'b1; b_p0_addr = 16'h0050; b_p0_wdata = 16'h7777;
      @(negedge clk);
      total_cnt++; if (b_mem_w !== 1'b1) $display("FAIL abort_started got %b exp 1", b_mem_w); else pass_cnt++;
      @(negedge clk);
      b_reset = 1'b1; b_p0_req = 1'b0;
      @(negedge clk);
      total_cnt++; if ({b_mem_w, b_mem_r, b_p0_ack, b_p1_ack} !== 4'b0)
         $display("FAIL abort_strobes got %b exp 0000", {b_mem_w, b_mem_r, b_p0_ack, b_p1_ack}); else pass_cnt++;
      b_reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total_cnt++; if ({b_p0_ack, b_p1_ack, b_mem_w, b_mem_r} !== 4'b0)
            $display("FAIL abort_quiet[%0d] got %b exp 0000", i, {b_p0_ack, b_p1_ack, b_mem_w, b_mem_r}); else pass_cnt++;
      end
      b_p0_req = 1'b1; b_p0_we = 1'b0; b_p0_addr = 16'h0050;
      b_p1_req = 1'b1; b_p1_we = 1'b0; b_p1_addr = 16'h0040;
      @(negedge clk);
      total_cnt++; if ({b_mem_r, b_mem_addr} !== {1'b1, 16'h0050})
         $display("FAIL abort_tie_p0 got %h exp 10050", {b_mem_r, b_mem_addr}); else pass_cnt++;
      for (int c = 0; c < 30 && (b_p0_req || b_p1_req); c++) begin
         @(negedge clk);
         if (b_p0_ack) begin acks++; b_p0_req = 1'b0; end
         if (b_p1_ack) begin acks++; rd1 = b_p1_rdata; b_p1_req = 1'b0; end
      end
      b_p0_req = 1'b0; b_p1_req = 1'b0;
      total_cnt++; if (acks != 2) $display("FAIL abort_drain_acks got %0d exp 2", acks); else pass_cnt++;
      total_cnt++; if (rd1 !== 16'h00A5) $display("FAIL abort_p1_rdata got %h exp 00a5", rd1); else pass_cnt++;
   endtask

   // Accesses are serialised, so applying each ack to a reference memory in ack order
   // gives the value every read must return.
   task automatic test_random();
      logic [15:0] ref_mem [0:7];
      bit          ref_ok  [0:7];
      bit          act     [0:1];
      bit          pwe     [0:1];
      logic [2:0]  pidx    [0:1];
      logic [15:0] pwd     [0:1];
      int          pstart  [0:1];
      int          nacc = 0;
      bit          ack;
      logic [15:0] rd;
      for (int i = 0; i < 8; i++) ref_ok[i] = 1'b0;
      for (int p = 0; p < 2; p++) act[p] = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         total_cnt++; if (a_p0_ack && a_p1_ack) $display("FAIL rnd_dual_ack got 11 exp not-both at %0d", c); else pass_cnt++;
         total_cnt++; if (a_cpu_stall !== (a_p0_req & ~a_p0_ack))
            $display("FAIL rnd_stall got %b exp %b at %0d", a_cpu_stall, a_p0_req & ~a_p0_ack, c); else pass_cnt++;
         for (int p = 0; p < 2; p++) begin
            ack = (p == 1) ? a_p1_ack : a_p0_ack;
            rd  = (p == 1) ? a_p1_rdata : a_p0_rdata;
            if (act[p] && ack) begin
               total_cnt++; if (c - pstart[p] < 2 || c - pstart[p] > 6)
                  $display("FAIL rnd_latency p%0d got %0d exp 2..6", p, c - pstart[p]); else pass_cnt++;
               if (pwe[p]) begin
                  ref_mem[pidx[p]] = pwd[p];
                  ref_ok[pidx[p]]  = 1'b1;
               end else if (ref_ok[pidx[p]]) begin
                  total_cnt++; if (rd !== ref_mem[pidx[p]])
                     $display("FAIL rnd_rdata p%0d got %h exp %h", p, rd, ref_mem[pidx[p]]); else pass_cnt++;
               end
               act[p] = 1'b0;
               nacc++;
            end else if (act[p] && c - pstart[p] > 6) begin
               total_cnt++; $display("FAIL rnd_timeout p%0d got %0d cycles exp <=6", p, c - pstart[p]);
               act[p] = 1'b0;
            end else if (!act[p] && ack) begin
               total_cnt++; $display("FAIL rnd_spurious_ack p%0d got 1 exp 0", p);
            end
            if (!act[p] && c < 500 && $urandom_range(0, 2) != 0) begin
               act[p]    = 1'b1;
               pwe[p]    = 1'($urandom_range(0, 1));
               pidx[p]   = 3'($urandom_range(0, 7));
               pwd[p]    = 16'($urandom);
               pstart[p] = c;
            end
         end
         a_p0_req = act[0]; a_p0_we = pwe[0]; a_p0_addr = {13'h0020, pidx[0]}; a_p0_wdata = pwd[0];
         a_p1_req = act[1]; a_p1_we = pwe[1]; a_p1_addr = {13'h0020, pidx[1]}; a_p1_wdata = pwd[1];
      end
      total_cnt++; if (act[0] || act[1]) $display("FAIL rnd_outstanding got %b%b exp 00", act[0], act[1]); else pass_cnt++;
      total_cnt++; if (nacc < 100) $display("FAIL rnd_traffic got %0d exp >=100", nacc); else pass_cnt++;
   endtask

   initial begin
      a_reset = 1'b1; b_reset = 1'b1;
      a_p0_req = 1'b0; a_p0_we = 1'b0; a_p0_addr = '0; a_p0_wdata = '0;
      a_p1_req = 1'b0; a_p1_we = 1'b0; a_p1_addr = '0; a_p1_wdata = '0;
      b_p0_req = 1'b0; b_p0_we = 1'b0; b_p0_addr = '0; b_p0_wdata = '0;
      b_p1_req = 1'b0; b_p1_we = 1'b0; b_p1_addr = '0; b_p1_wdata = '0;
      test_reset();
      test_write_read();
      test_tie();
      test_contention();
      test_latency4();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
